mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 8-bit external memory bus between the two micro-op issue slots: the scheduler slot (0) and the main slot (1). Each slot issues byte or word, read or write requests. The block arbitrates round-robin and serialises each word access into two little-endian byte beats. It returns read data and a one-cycle completion strobe to the owning slot, and asserts a per-slot stall while that slot's request is outstanding. It sits between the uop execute stage's memory-request outputs and the bus interface unit.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge.
- a_rst  in  1  reset, asynchronous, active-high.
- rq_0 / rq_1  in  1  slot request; held high until that slot's done.
- cmd_0 / cmd_1  in  1  0 = read, 1 = write.
- width_0 / width_1  in  1  0 = byte, 1 = word (16-bit).
- addr_0 / addr_1  in  16  byte address.
- wdata_0 / wdata_1  in  16  write data; byte writes use [7:0].
- stall_0 / stall_1  out  1  rq_x & ~done_x, combinational.
- done_0 / done_1  out  1  one-cycle completion strobe, registered.
- rdata  out  16  read result; valid in the done cycle and held until the next done.
- busy  out  1  state != IDLE.
- bus_req  out  1  beat request to the bus unit.
- bus_we  out  1  beat is a write.
- bus_addr  out  16  beat address.
- bus_wdata  out  8  beat write byte.
- bus_rdata  in  8  beat read byte; valid with bus_ack.
- bus_ack  in  1  beat completes in this cycle.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- **IDLE**
  - Eligible slots are those with rq high, excluding the slot masked this cycle.
  - One eligible slot: grant it.
  - Both eligible: grant the slot not granted last. The last-granted pointer resets to slot 1, so slot 0 wins the first conflict.
  - On grant, latch owner, cmd, width, addr and wdata, update the pointer, and go to LO.
- **LO**
  - bus_req = 1, bus_addr = latched addr, bus_we = cmd, bus_wdata = wdata[7:0].
  - On bus_ack: a read captures bus_rdata into rdata[7:0]. Go to HI if width = 1, else DONE.
  - Without ack, hold all bus outputs stable.
- **HI**
  - bus_req = 1, bus_addr = addr + 1 (16-bit wrap: 0xFFFF -> 0x0000), bus_wdata = wdata[15:8].
  - On bus_ack: a read captures bus_rdata into rdata[15:8]. Go to DONE.
- **DONE**
  - done_owner = 1 for exactly this cycle; bus_req = 0. Go to IDLE.
  - A byte read returns rdata = {8'h00, byte}.
  - Write completions leave rdata unchanged.
- **Mask rule:** in the IDLE cycle immediately after DONE, the just-served slot's rq is ignored. A requester dropping rq one cycle after done is therefore never re-served. Back-to-back requests from the same slot cost one extra cycle.
- Requests arriving mid-transaction wait, with stall high.
- Changes to a pending slot's inputs before its grant are permitted; inputs are sampled only at grant.
- Reset values:
  - state IDLE; pointer = slot 1.
  - bus_req, bus_we, done_0, done_1, busy = 0.
  - bus_addr, bus_wdata, rdata = 0.
- **Reset mid-transaction:** the FSM returns to IDLE at once, bus_req drops asynchronously, and no done is issued for the aborted request.

## Timing
- Cycle n = first cycle rq is high and the slot wins in IDLE.
- Byte access with immediate ack: LO at n+1, DONE at n+2, so done is high in cycle n+2.
- Word access with immediate acks: LO n+1, HI n+2, DONE n+3.
- Each cycle without bus_ack adds one cycle of latency.
- bus_req, bus_addr, bus_we and bus_wdata are registered/state-decoded and glitch-free. They change only on clock edges or on async reset.
- stall_x is combinational from rq_x and the registered done_x.
- Max throughput: one byte access per 3 cycles under continuous alternating requests.

## Test plan
- **Reset:** a_rst pulsed high mid-LO with bus_req = 1 -> bus_req falls without waiting for clk, all outputs return to reset values, no done pulse follows.
- **Byte read:** slot 0 reads addr 0x1234, bus_ack immediate, bus_rdata = 0xA5 -> bus_addr = 0x1234 at n+1, done_0 at n+2, rdata = 0x00A5, stall_0 high n..n+1.
- **Word write wrap:** slot 1 writes 0xBEEF at addr 0xFFFF -> beat 1 addr 0xFFFF data 0xEF, beat 2 addr 0x0000 data 0xBE, done_1 at n+3, rdata unchanged.
- **Round-robin conflict:** both slots request word reads from reset -> slot 0 served first; slot 1 granted in the IDLE after slot 0's DONE; stall_1 high throughout.
- **Wait states:** word read with bus_ack delayed 2 cycles per beat, bytes 0x34 then 0x12 -> done at n+7, rdata = 0x1234, bus_addr stable during waits.
- **Mask rule:** slot 0 holds rq high one cycle past done_0, slot 1 idle -> no second grant to slot 0 in that IDLE cycle. A slot 0 request in the following cycle is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Slot request ports and 8-bit beat port of the shared memory bus arbiter.
// slave = arbiter side, master = execute stage / bus unit side.
interface mem_port_arbiter_if;
  logic        rq_0;
  logic        rq_1;
  logic        cmd_0;
  logic        cmd_1;
  logic        width_0;
  logic        width_1;
  logic [15:0] addr_0;
  logic [15:0] addr_1;
  logic [15:0] wdata_0;
  logic [15:0] wdata_1;
  logic        stall_0;
  logic        stall_1;
  logic        done_0;
  logic        done_1;
  logic [15:0] rdata;
  logic        busy;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport slave (
    input  rq_0, rq_1, cmd_0, cmd_1, width_0, width_1,
    input  addr_0, addr_1, wdata_0, wdata_1,
    input  bus_rdata, bus_ack,
    output stall_0, stall_1, done_0, done_1, rdata, busy,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output rq_0, rq_1, cmd_0, cmd_1, width_0, width_1,
    output addr_0, addr_1, wdata_0, wdata_1,
    output bus_rdata, bus_ack,
    input  stall_0, stall_1, done_0, done_1, rdata, busy,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the 8-bit memory bus between two issue slots;
// words are split into two little-endian byte beats.
module mem_port_arbiter (
  input logic               clk,
  input logic               a_rst,
  mem_port_arbiter_if.slave mp
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  state_t      state_d;
  logic        owner;
  logic        last;
  logic        after_done;
  logic        cmd_q;
  logic        width_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;
  logic        req_q;
  logic        we_q;
  logic [15:0] baddr_q;
  logic [7:0]  bwdata_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        done0_q;
  logic        done1_q;

  logic        elig_0;
  logic        elig_1;
  logic        grant;
  logic        gslot;
  logic        sel_cmd;
  logic        sel_width;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // the slot served last is ignored for one IDLE cycle after its DONE
  assign elig_0 = mp.rq_0 & ~(after_done & ~owner);
  assign elig_1 = mp.rq_1 & ~(after_done & owner);
  assign grant  = elig_0 | elig_1;

  always_comb begin
    gslot = 1'b0;
    if (elig_0 && elig_1) gslot = ~last;
    else if (elig_1)      gslot = 1'b1;
  end

  assign sel_cmd   = gslot ? mp.cmd_1   : mp.cmd_0;
  assign sel_width = gslot ? mp.width_1 : mp.width_0;
  assign sel_addr  = gslot ? mp.addr_1  : mp.addr_0;
  assign sel_wdata = gslot ? mp.wdata_1 : mp.wdata_0;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (grant) state_d = LO;
      LO:   if (mp.bus_ack) state_d = width_q ? HI : DONE;
      HI:   if (mp.bus_ack) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_d;
  end

  // bus outputs are flops so they only move on clock edges or reset
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      owner      <= 1'b0;
      last       <= 1'b1;
      after_done <= 1'b0;
      cmd_q      <= 1'b0;
      width_q    <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      lo_q       <= 8'h00;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      baddr_q    <= 16'h0000;
      bwdata_q   <= 8'h00;
      rdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      after_done <= (state == DONE);
      busy_q     <= (state_d != IDLE);
      done0_q    <= (state_d == DONE) & ~owner;
      done1_q    <= (state_d == DONE) & owner;
      unique case (state)
        IDLE: if (grant) begin
          owner    <= gslot;
          last     <= gslot;
          cmd_q    <= sel_cmd;
          width_q  <= sel_width;
          addr_q   <= sel_addr;
          wdata_q  <= sel_wdata;
          req_q    <= 1'b1;
          we_q     <= sel_cmd;
          baddr_q  <= sel_addr;
          bwdata_q <= sel_wdata[7:0];
        end
        LO: if (mp.bus_ack) begin
          lo_q <= mp.bus_rdata;
          if (width_q) begin
            baddr_q  <= addr_q + 16'd1;
            bwdata_q <= wdata_q[15:8];
          end else begin
            req_q <= 1'b0;
            if (!cmd_q) rdata_q <= {8'h00, mp.bus_rdata};
          end
        end
        HI: if (mp.bus_ack) begin
          req_q <= 1'b0;
          if (!cmd_q) rdata_q <= {mp.bus_rdata, lo_q};
        end
        default: ;
      endcase
    end
  end

  assign mp.stall_0   = mp.rq_0 & ~done0_q;
  assign mp.stall_1   = mp.rq_1 & ~done1_q;
  assign mp.done_0    = done0_q;
  assign mp.done_1    = done1_q;
  assign mp.rdata     = rdata_q;
  assign mp.busy      = busy_q;
  assign mp.bus_req   = req_q;
  assign mp.bus_we    = we_q;
  assign mp.bus_addr  = baddr_q;
  assign mp.bus_wdata = bwdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences,
// and random traffic against a transaction-level memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if mp();
  mem_port_arbiter dut (.clk(clk), .a_rst(a_rst), .mp(mp));

  typedef struct {
    logic        slot;
    logic        cmd;
    logic        width;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
    int          dly;
    int          done_k;
    logic [15:0] rdata;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  int          checks;
  int          errors;
  int          cnt;
  int          ack_dly;
  bit          rand_ack;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wd;
  logic [7:0]  bus_mem [bit [15:0]];
  logic [7:0]  ref_mem [bit [15:0]];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bus_rd(input bit [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input bit [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic get_done(input int s);
    return (s == 0) ? mp.done_0 : mp.done_1;
  endfunction

  function automatic logic get_stall(input int s);
    return (s == 0) ? mp.stall_0 : mp.stall_1;
  endfunction

  task automatic set_slot(input int s, input logic rq, input logic cmd,
                          input logic w, input logic [15:0] a,
                          input logic [15:0] wd);
    if (s == 0) begin
      mp.rq_0 = rq; mp.cmd_0 = cmd; mp.width_0 = w;
      mp.addr_0 = a; mp.wdata_0 = wd;
    end else begin
      mp.rq_1 = rq; mp.cmd_1 = cmd; mp.width_1 = w;
      mp.addr_1 = a; mp.wdata_1 = wd;
    end
  endtask

  // advance to the next falling edge and play the bus unit
  task automatic tick();
    @(negedge clk);
    mp.bus_ack = 1'b0;
    if (mp.bus_req) begin
      cnt++;
      if (cnt > 1) begin
        check("bus_addr_stable", mp.bus_addr, prev_addr);
        check("bus_wdata_stable", mp.bus_wdata, prev_wd);
      end
      prev_addr = mp.bus_addr;
      prev_wd   = mp.bus_wdata;
      if (rand_ack ? ($urandom_range(0, 1) == 0) : (cnt > ack_dly)) begin
        mp.bus_ack   = 1'b1;
        mp.bus_rdata = bus_rd(mp.bus_addr);
        if (mp.bus_we) bus_mem[mp.bus_addr] = mp.bus_wdata;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          k;
    int          beats;
    bit          seen;
    int          s;
    logic [15:0] ba [2];
    logic [7:0]  bd [2];
    logic        bw;
    s = int'(v.slot);
    bus_mem[v.addr] = v.rb0;
    bus_mem[v.addr + 16'd1] = v.rb1;
    ack_dly = v.dly;
    ba[0] = 16'h0; ba[1] = 16'h0; bd[0] = 8'h0; bd[1] = 8'h0; bw = 1'b0;
    repeat (2) tick();
    tick();
    set_slot(s, 1'b1, v.cmd, v.width, v.addr, v.wdata);
    seen = 0;
    beats = 0;
    k = 0;
    while (!seen && k < 40) begin
      k++;
      tick();
      if (mp.bus_ack && beats < 2) begin
        ba[beats] = mp.bus_addr;
        bd[beats] = mp.bus_wdata;
        if (beats == 0) bw = mp.bus_we;
        beats++;
      end
      check($sformatf("v%0d_stall", idx), get_stall(s),
            (k < v.done_k) ? 1 : 0);
      check($sformatf("v%0d_other_done", idx), get_done(1 - s), 0);
      if (get_done(s)) begin
        seen = 1;
        check($sformatf("v%0d_done_cycle", idx), k, v.done_k);
        check($sformatf("v%0d_rdata", idx), mp.rdata, v.rdata);
        set_slot(s, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    if (!seen) check($sformatf("v%0d_done_timeout", idx), 0, 1);
    check($sformatf("v%0d_beats", idx), beats, v.width ? 2 : 1);
    check($sformatf("v%0d_bus_we", idx), bw, v.cmd);
    check($sformatf("v%0d_addr0", idx), ba[0], v.a0);
    if (v.cmd) check($sformatf("v%0d_wbyte0", idx), bd[0], v.d0);
    if (v.width) begin
      check($sformatf("v%0d_addr1", idx), ba[1], v.a1);
      if (v.cmd) check($sformatf("v%0d_wbyte1", idx), bd[1], v.d1);
    end
  endtask

  initial begin : main
    int          d0k;
    int          d1k;
    bit          act [2];
    logic        cm [2];
    logic        wm [2];
    logic [15:0] am [2];
    logic [15:0] dm [2];
    int          others [2];
    logic        dn [2];
    logic [15:0] model_rdata;
    logic [15:0] expv;
    logic [15:0] base;
    int          ndone;

    checks = 0; errors = 0; cnt = 0; ack_dly = 0; rand_ack = 0;
    prev_addr = 16'h0; prev_wd = 8'h0;
    set_slot(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_slot(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mp.bus_ack = 1'b0;
    mp.bus_rdata = 8'h00;

    //         slot cmd  wid  addr      wdata     rb0    rb1  dly k rdata     a0        a1        d0     d1
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'hA5, 8'h00, 0, 2, 16'h00A5, 16'h1234, 16'h0000, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 8'h00, 8'h00, 0, 3, 16'h00A5, 16'hFFFF, 16'h0000, 8'hEF, 8'hBE};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h2000, 16'h0000, 8'h34, 8'h12, 2, 7, 16'h1234, 16'h2000, 16'h2001, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 8'h7E, 8'h00, 1, 3, 16'h007E, 16'h00FF, 16'h0000, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h11, 8'h22, 0, 3, 16'h2211, 16'hFFFF, 16'h0000, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0042, 16'hAB99, 8'h00, 8'h00, 0, 2, 16'h2211, 16'h0042, 16'h0000, 8'h99, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h1000, 16'hCAFE, 8'h00, 8'h00, 1, 5, 16'h2211, 16'h1000, 16'h1001, 8'hFE, 8'hCA};

    a_rst = 1'b1;
    #12;
    check("rst_bus_req", mp.bus_req, 0);
    check("rst_bus_we", mp.bus_we, 0);
    check("rst_bus_addr", mp.bus_addr, 0);
    check("rst_bus_wdata", mp.bus_wdata, 0);
    check("rst_rdata", mp.rdata, 0);
    check("rst_busy", mp.busy, 0);
    check("rst_done", {mp.done_1, mp.done_0}, 0);
    check("rst_stall", {mp.stall_1, mp.stall_0}, 0);
    tick();
    a_rst = 1'b0;

    // reset while the first beat is waiting for ack
    ack_dly = 5;
    tick();
    set_slot(0, 1'b1, 1'b0, 1'b0, 16'h0440, 16'h0);
    tick();
    check("rm_bus_req_lo", mp.bus_req, 1);
    check("rm_bus_addr_lo", mp.bus_addr, 16'h0440);
    #1 a_rst = 1'b1;
    #1;
    check("rm_bus_req_async", mp.bus_req, 0);
    check("rm_busy", mp.busy, 0);
    check("rm_bus_addr", mp.bus_addr, 0);
    check("rm_rdata", mp.rdata, 0);
    set_slot(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    a_rst = 1'b0;
    repeat (6) begin
      tick();
      check("rm_no_done", {mp.done_1, mp.done_0}, 0);
    end

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // round robin from reset: slot 0 first, slot 1 after
    repeat (2) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    ack_dly = 0;
    bus_mem[16'h0300] = 8'h5A; bus_mem[16'h0301] = 8'h5B;
    bus_mem[16'h0510] = 8'h4A; bus_mem[16'h0511] = 8'h4B;
    tick();
    set_slot(0, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0);
    set_slot(1, 1'b1, 1'b0, 1'b1, 16'h0510, 16'h0);
    #1 check("rr_stall_1_k0", mp.stall_1, 1);
    d0k = 0; d1k = 0;
    for (int k = 1; k <= 20 && d1k == 0; k++) begin
      tick();
      if (mp.done_0 && d0k == 0) begin
        d0k = k;
        check("rr_rdata_0", mp.rdata, 16'h5B5A);
        set_slot(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      if (mp.done_1) begin
        d1k = k;
        check("rr_rdata_1", mp.rdata, 16'h4B4A);
        set_slot(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end else begin
        check("rr_stall_1", mp.stall_1, 1);
      end
    end
    check("rr_done0_cycle", d0k, 3);
    check("rr_done1_cycle", d1k, 7);

    // slot 0 holds rq one cycle past done; must not be re-served then
    repeat (2) tick();
    tick();
    set_slot(0, 1'b1, 1'b0, 1'b0, 16'h0510, 16'h0);
    tick();
    tick();
    check("mk_done_k2", mp.done_0, 1);
    check("mk_rdata", mp.rdata, 16'h004A);
    tick();
    check("mk_stall_k3", mp.stall_0, 1);
    check("mk_bus_req_k3", mp.bus_req, 0);
    tick();
    check("mk_bus_req_k4", mp.bus_req, 0);
    check("mk_busy_k4", mp.busy, 0);
    tick();
    check("mk_bus_req_k5", mp.bus_req, 1);
    tick();
    check("mk_done_k6", mp.done_0, 1);
    set_slot(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) tick();

    // random traffic against a transaction-level memory model
    ref_mem = bus_mem;
    model_rdata = 16'h004A;
    rand_ack = 1;
    ndone = 0;
    for (int s = 0; s < 2; s++) begin
      act[s] = 0; cm[s] = 0; wm[s] = 0; am[s] = 0; dm[s] = 0; others[s] = 0;
    end
    for (int c = 0; c < 3100; c++) begin
      tick();
      dn[0] = mp.done_0;
      dn[1] = mp.done_1;
      for (int s = 0; s < 2; s++) begin
        check("rnd_stall", get_stall(s), act[s] & ~dn[s]);
        if (dn[s] && !act[s]) check("rnd_spurious_done", 1, 0);
        if (dn[s] && act[s]) begin
          ndone++;
          if (cm[s]) begin
            ref_mem[am[s]] = dm[s][7:0];
            if (wm[s]) ref_mem[am[s] + 16'd1] = dm[s][15:8];
            check("rnd_wr_rdata", mp.rdata, model_rdata);
          end else begin
            expv = wm[s] ? {ref_rd(am[s] + 16'd1), ref_rd(am[s])}
                         : {8'h00, ref_rd(am[s])};
            check("rnd_rd_rdata", mp.rdata, expv);
            model_rdata = expv;
          end
          check("rnd_fair", others[s] <= 1, 1);
          act[s] = 0;
          others[s] = 0;
          set_slot(s, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
          if (act[1 - s]) others[1 - s]++;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (c < 3000 && !act[s] && !dn[s] && $urandom_range(0, 2) == 0) begin
          act[s] = 1;
          cm[s] = 1'($urandom_range(0, 1));
          wm[s] = 1'($urandom_range(0, 1));
          base = ($urandom_range(0, 1) == 1) ? 16'hFFF8 : 16'h0040;
          am[s] = base + 16'($urandom_range(0, 7));
          dm[s] = 16'($urandom_range(0, 65535));
          set_slot(s, 1'b1, cm[s], wm[s], am[s], dm[s]);
        end
      end
    end
    check("rnd_drained", {act[1], act[0]}, 0);
    check("rnd_enough_done", ndone > 200, 1);
    foreach (ref_mem[a]) check("rnd_mem", bus_rd(a), ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
